adder9_sum_accumulator: RTL and testbench
=========================================

# adder9_sum_accumulator

Downstream stage of the 9-bit ripple-carry adder: consumes its 10-bit `sum` one sample per valid/ready handshake and accumulates a fixed-size batch of `COUNT` samples. When the batch completes it presents the batch total and the batch maximum to the next stage, and holds them until accepted. It gives the combinational adder a registered, flow-controlled output path for the cascaded-adder datapath.

## Interface
Parameters:
- `COUNT`, 4: samples per batch; legal range 2..256.
- `ACC_W`, 12: accumulator width; must satisfy `ACC_W >= 10 + $clog2(COUNT)`, checked at elaboration with a fatal error.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `clear` in 1: synchronous batch abort.
- `in_valid` in 1: `in_sum` is valid.
- `in_ready` out 1: block accepts a sample this cycle.
- `in_sum` in 10: adder `sum` output, unsigned, 0..1023.
- `out_valid` out 1: batch result is valid.
- `out_ready` in 1: downstream accepts the result.
- `out_acc` out `ACC_W`: unsigned sum of the batch samples.
- `out_max` out 10: largest sample in the batch.

## Operation
- Two states, `ACC` and `DONE`. Internal registers: `acc` (`ACC_W`), `max` (10), and `cnt` (`$clog2(COUNT)+1`).
- `in_ready = (state == ACC)`, combinational from state only. `out_valid = (state == DONE)`.
- Accept means `in_valid && in_ready`. On accept:
  - `acc <= acc + in_sum`, with `in_sum` zero-extended.
  - `max <= (in_sum > max) ? in_sum : max`.
  - `cnt <= cnt + 1`.
- When an accept makes `cnt + 1 == COUNT`, go to `DONE`.
- `out_acc` and `out_max` are driven directly from `acc` and `max`. They are stable throughout `DONE`.
- In `DONE`, `out_valid && out_ready` returns to `ACC` and sets `acc`, `max`, `cnt` to 0. No sample is accepted in that cycle, because `in_ready` is 0.
- Arithmetic cannot overflow given the parameter rule. No saturation logic.
- `clear` has highest priority, from any state:
  - next state `ACC`, and `acc`, `max`, `cnt` go to 0;
  - an input or output handshake in the same cycle is discarded;
  - a result held in `DONE` is dropped.
- `in_valid` may drop between samples. Gaps do not affect the result.

## Timing
- Reset values: state `ACC`, `acc = 0`, `max = 0`, `cnt = 0`. Hence `in_ready = 1`, `out_valid = 0`, `out_acc = 0`, `out_max = 0`.
- Reset assertion mid-batch discards the partial batch immediately, asynchronously. Deassertion is synchronised externally.
- Latency: the final sample is accepted at edge t; `out_valid = 1` from edge t, so it is visible in the cycle after the accepting cycle.
- Throughput: at most one batch per `COUNT + 1` cycles, because of the one-cycle `DONE` bubble when `out_ready` is held high.
- Backpressure: while `out_ready = 0` in `DONE`, all outputs hold and `in_ready` stays 0 indefinitely.
- Upstream must hold `in_sum` stable while `in_valid && !in_ready`. The block does not depend on this, because it samples only on accept.

## Structure
- Shared package `adder9_pkg`:
  - `localparam SUM_W = 10`;
  - `typedef enum logic {ACC, DONE} acc_state_t`.
- Single flat module with no sub-modules. The counter, the comparator and the adder are inline `always_ff` / `always_comb` logic.
- The enclosing design instantiates it directly after the 9-bit adder, tied to its `sum`.

## Test plan
- Reset, then samples 1, 2, 3, 4 back-to-back with `out_ready = 1` → `out_valid` for one cycle with `out_acc = 10`, `out_max = 4`; `in_ready` is 0 for exactly that cycle.
- Four samples of 1023 → `out_acc = 4092`, `out_max = 1023`. Repeat with `COUNT = 256`, `ACC_W = 18` and all samples 1023 → `out_acc = 261888`.
- Batch 7, 0, 9, 2, then hold `out_ready = 0` for 5 cycles:
  - `out_valid = 1`, `out_acc = 18`, `out_max = 9` stable throughout;
  - `in_ready = 0` with `in_valid = 1` driven throughout;
  - when `out_ready` rises, the handshake occurs and the next sample is accepted one cycle later.
- Samples 100, 200, then `clear` asserted together with `in_valid` and `in_sum = 50`, then 5, 5, 5, 5 → result `out_acc = 20`, `out_max = 5`. The 50 is discarded.
- `in_valid` toggled with 1–3 idle cycles between samples 3, 1, 4, 1 → `out_acc = 9`, `out_max = 4`.
- Reset mid-batch:
  - assert `rst_n = 0` asynchronously after 2 samples → outputs 0 and `in_ready = 1` before the next clock edge;
  - then a fresh batch 8, 8, 8, 8 → `out_acc = 32`.

Source files
------------

// File: rtl/adder9_pkg.sv
// ============================================================================
//  Module      : adder9_pkg
//  Description : Shared types and constants for the 9-bit adder datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder9_pkg;

   // Width of the 9-bit adder's sum output (carry included)
   localparam int SUM_W = 10;

   // Accumulator control states
   typedef enum logic {
      ACC  = 1'b0,
      DONE = 1'b1
   } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/adder9_sum_accumulator.sv
// ============================================================================
//  Module      : adder9_sum_accumulator
//  Description : Accumulates a batch of COUNT adder sums over a valid/ready
//                handshake, then presents the batch total and maximum and
//                holds them until the downstream stage accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder9_sum_accumulator
   import adder9_pkg::*;
#(
   parameter int COUNT = 4,
   parameter int ACC_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SUM_W-1:0]    in_sum,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    out_acc,
   output logic [SUM_W-1:0]    out_max
);

   localparam int CNT_W = $clog2(COUNT) + 1;
   // Count value held just before the final sample of a batch is accepted
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   // Reject parameter sets where the batch total could overflow the accumulator
   generate
      if ((COUNT < 2) || (COUNT > 256) || (ACC_W < SUM_W + $clog2(COUNT))) begin : g_param_check
         $fatal(1, "adder9_sum_accumulator: illegal COUNT/ACC_W combination");
      end
   endgenerate

   acc_state_t       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [SUM_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Handshake flags depend on state only, so no combinational path from inputs
   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == DONE);
   assign out_acc   = acc_q;
   assign out_max   = max_q;

   // Next-state and datapath update: clear overrides both handshakes
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = ACC;
         acc_d   = '0;
         max_d   = '0;
         cnt_d   = '0;
      end else if (state_q == ACC) begin
         if (in_valid) begin
            acc_d = acc_q + ACC_W'(in_sum);
            max_d = (in_sum > max_q) ? in_sum : max_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
      end else begin
         // Result consumed: restart with an empty batch, no sample taken this cycle
         if (out_ready) begin
            state_d = ACC;
            acc_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
         end
      end
   end

   // State and datapath registers; reset drops any partial batch immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         acc_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adder9_sum_accumulator.sv
// ============================================================================
//  Module      : tb_adder9_sum_accumulator
//  Description : Self-checking bench for adder9_sum_accumulator (COUNT=4 and
//                COUNT=256 instances) against a batch sum/max reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder9_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   // COUNT = 4 instance
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  in_sum = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_acc;
   logic [9:0]  out_max;

   // COUNT = 256 instance
   logic        b_clear = 1'b0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [9:0]  b_in_sum = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [17:0] b_out_acc;
   logic [9:0]  b_out_max;

   int vectors = 0;
   int miscompares = 0;

   adder9_sum_accumulator #(.COUNT(4), .ACC_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_max   (out_max)
   );

   adder9_sum_accumulator #(.COUNT(256), .ACC_W(18)) dut256 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (b_clear),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_sum    (b_in_sum),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_acc   (b_out_acc),
      .out_max   (b_out_max)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample after a number of idle cycles, and take it in one edge
   task automatic feed(input int v, input int gaps);
      for (int g = 0; g < gaps; g++) begin
         in_valid = 1'b0;
         in_sum   = 10'($urandom);
         step();
      end
      in_valid = 1'b1;
      in_sum   = 10'(v);
      check("ready_before_sample", 32'(in_ready), 32'd1);
      check("no_result_mid_batch", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
   endtask

   // Reference model: a batch result is the plain sum and the maximum of its samples
   task automatic run_batch(input string tag, input int s[4], input int gmin, input int gmax,
                            input int hold);
      int exp_sum;
      int exp_max;
      exp_sum = 0;
      exp_max = 0;
      for (int i = 0; i < 4; i++) begin
         exp_sum += s[i];
         if (s[i] > exp_max) exp_max = s[i];
      end
      out_ready = (hold == 0);
      for (int i = 0; i < 4; i++) feed(s[i], (i == 0) ? 0 : int'($urandom_range(gmax, gmin)));
      // Backpressure: result held, input blocked even while offered
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_sum   = 10'($urandom);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_acc"},   32'(out_acc),   32'(exp_sum));
         check({tag, "_hold_max"},   32'(out_max),   32'(exp_max));
         check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_acc"},   32'(out_acc),   32'(exp_sum));
      check({tag, "_max"},   32'(out_max),   32'(exp_max));
      check({tag, "_ready"}, 32'(in_ready),  32'd0);
      step();
      check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(in_ready),  32'd1);
      check({tag, "_acc_after"},   32'(out_acc),   32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      int rs[4];

      // Reset state
      rst_n = 1'b0;
      step();
      step();
      check("reset_ready", 32'(in_ready),  32'd1);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_acc",   32'(out_acc),   32'd0);
      check("reset_max",   32'(out_max),   32'd0);
      rst_n = 1'b1;
      step();

      // Basic batch, back-to-back, out_ready high throughout
      run_batch("b1234", '{1, 2, 3, 4}, 0, 0, 0);
      // Full-scale samples
      run_batch("b1023", '{1023, 1023, 1023, 1023}, 0, 0, 0);

      // Backpressure for 5 cycles, then handshake and next sample one cycle later
      out_ready = 1'b0;
      feed(7, 0); feed(0, 0); feed(9, 0); feed(2, 0);
      for (int h = 0; h < 5; h++) begin
         in_valid = 1'b1;
         in_sum   = 10'd33;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_acc",   32'(out_acc),   32'd18);
         check("bp_max",   32'(out_max),   32'd9);
         check("bp_ready", 32'(in_ready),  32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      check("bp_handshake_valid", 32'(out_valid), 32'd0);
      check("bp_handshake_acc",   32'(out_acc),   32'd0);
      out_ready = 1'b0;
      step();
      check("bp_next_accepted", 32'(out_acc), 32'd33);
      in_valid = 1'b0;

      // Clear with a concurrent sample (batch already holds 33, then 100, 200)
      feed(100, 0);
      feed(200, 0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_sum   = 10'd50;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clear_acc",   32'(out_acc),   32'd0);
      check("clear_max",   32'(out_max),   32'd0);
      check("clear_valid", 32'(out_valid), 32'd0);
      check("clear_ready", 32'(in_ready),  32'd1);
      run_batch("after_clear", '{5, 5, 5, 5}, 0, 0, 0);

      // Clear drops a result held in DONE
      out_ready = 1'b0;
      feed(11, 0); feed(12, 0); feed(13, 0); feed(14, 0);
      check("done_before_clear", 32'(out_valid), 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("done_clear_valid", 32'(out_valid), 32'd0);
      check("done_clear_acc",   32'(out_acc),   32'd0);

      // Gaps between samples do not affect the result
      run_batch("gaps", '{3, 1, 4, 1}, 1, 3, 0);

      // Randomized batches with random gaps and random backpressure
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < 4; k++) rs[k] = int'($urandom_range(1023, 0));
         run_batch($sformatf("rand%0d", b), rs, 0, 2, int'($urandom_range(3, 0)));
      end

      // Asynchronous reset mid-batch
      feed(6, 0);
      feed(7, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_acc",   32'(out_acc),   32'd0);
      check("async_rst_max",   32'(out_max),   32'd0);
      check("async_rst_ready", 32'(in_ready),  32'd1);
      check("async_rst_valid", 32'(out_valid), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      run_batch("post_reset", '{8, 8, 8, 8}, 0, 0, 0);

      // COUNT = 256 instance, all samples full-scale
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_sum    = 10'd1023;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) check("c256_no_early_result", 32'(b_out_valid), 32'd0);
         step();
      end
      b_in_valid = 1'b0;
      check("c256_valid", 32'(b_out_valid), 32'd1);
      check("c256_acc",   32'(b_out_acc),   32'd261888);
      check("c256_max",   32'(b_out_max),   32'd1023);
      step();
      check("c256_consumed", 32'(b_out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
